fft_twiddle_gen: RTL
====================

Name: fft_twiddle_gen

Overview:
- Per-sample twiddle sequencer for one radix-2 single-path-delay-feedback (SDF) DIF FFT stage.
- Sits directly upstream of the stage's CORDIC rotator.
- Accepts the butterfly's complex output stream, counts samples within the frame, and computes the twiddle phase for each sample as the rotator's {quad, angle} pair.
- Emits data and phase aligned on the same cycle, so the rotator applies the twiddle with no further alignment.

Parameters:
- DATA_WIDTH, 16: signed width of real/imag samples.
- PHASE_WIDTH, 18: width of the angle output (fraction of a quarter turn).
- LOG2N, 10: log2 of FFT size N. Constraint: LOG2N <= PHASE_WIDTH+2.
- STAGE, 0: stage index s, range 0..LOG2N-1. Block length L = N>>s, half H = L/2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_sop  in  1  first sample of frame; qualified by in_valid
- in_real  in  DATA_WIDTH  signed real part
- in_imag  in  DATA_WIDTH  signed imaginary part
- out_valid  out  1  output sample valid
- out_sop  out  1  first sample of frame
- out_real  out  DATA_WIDTH  delayed in_real
- out_imag  out  DATA_WIDTH  delayed in_imag
- angle  out  PHASE_WIDTH  twiddle angle within quadrant, to rotator
- quad  out  2  twiddle quadrant, to rotator
- sop_err  out  1  one-cycle pulse: frame misalignment detected

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values (rst=1 at a clk edge): all outputs 0, state=IDLE, sample counter n=0, phase accumulator P=0. Reset mid-frame abandons the frame; no output follows until the next in_sop.
- Phase encoding: P is an unsigned (PHASE_WIDTH+2)-bit word, theta = 2*pi*P / 2^(PHASE_WIDTH+2). quad = P[PHASE_WIDTH+1:PHASE_WIDTH], angle = P[PHASE_WIDTH-1:0].
- Twiddle for a sample at in-block position j = n mod L:
  - j < H: W = 1, so P = 0.
  - j >= H: k = j-H, W = exp(-j*2*pi*k*2^s/N), so P = (-k * STEP) mod 2^(PHASE_WIDTH+2), where STEP = 2^(PHASE_WIDTH+2-LOG2N+s).
  - Implementation: accumulator cleared at j=H-1, decremented by STEP on each accepted sample with j >= H. No multiplier.
- Latency: exactly 1 clk. out_* for sample n appear on the cycle after in_valid. No backpressure; the stream may have gaps (in_valid=0). Gaps hold n and P; out_valid=0 during gaps, other outputs hold their last value.
- State machine:
  - IDLE:
    - in_valid & in_sop: accept as n=0, go to RUN.
    - in_valid & !in_sop: sample discarded, out_valid stays 0, sop_err=1 for one cycle.
  - RUN: each in_valid increments n.
    - Sample with n=N-1 accepted: return to IDLE, n=0.
    - in_sop on the n=N-1 sample: not an error; the frame ends normally.
    - in_sop with 0 < n < N (mid-frame): that sample restarts the frame as n=0, P=0, sop_err pulses, state stays RUN.
- out_sop = 1 exactly on the output cycle of each accepted n=0 sample.
- Back-to-back frames: in_sop on the cycle immediately after n=N-1 is accepted with no bubble.
- Data passes through unmodified (no width change, no rounding).

Test Plan:
1. LOG2N=4, STAGE=1 (L=8, H=4, STEP=2^17), continuous valid with in_sop at n=0 -> outputs one cycle later:
   - n=0..3: quad=00, angle=0.
   - n=4: quad 00, angle 0x00000.
   - n=5: quad 11, angle 0x20000.
   - n=6: quad 11, angle 0x00000.
   - n=7: quad 10, angle 0x20000.
   - n=8..15: pattern repeats.
   - out_sop only at n=0.
2. Same config, random in_valid gaps -> identical quad/angle sequence across valid cycles; out_valid mirrors in_valid delayed 1 cycle; data matches input.
3. in_valid without in_sop after reset -> out_valid stays 0, sop_err pulses once per such sample.
4. in_sop at n=6 mid-frame -> sop_err=1 one cycle; that sample is output with quad=00, angle=0 and out_sop=1; counting restarts.
5. Two frames back-to-back (sop on cycle 16) -> no bubble, no sop_err, second frame identical to the first.
6. rst asserted at n=5 for 1 cycle -> all outputs 0 next cycle; following samples are discarded until the next in_sop; STAGE=0 run then gives n=9 -> P = -1*2^16 mod 2^20 = 0xF0000 (quad=11, angle=0x30000).

Source files
------------

// File: rtl/fft_twiddle_gen.sv
// Twiddle sequencer for one radix-2 SDF DIF FFT stage: delays the butterfly
// output by one cycle and pairs each sample with its rotator {quad, angle}.
module fft_twiddle_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 18,
    parameter int LOG2N       = 10,
    parameter int STAGE       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sop,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic [PHASE_WIDTH-1:0]       angle,
    output logic [1:0]                   quad,
    output logic                         sop_err
);

    localparam int PW2   = PHASE_WIDTH + 2;
    localparam int BLK_W = LOG2N - STAGE;
    localparam logic [PW2-1:0]   STEP       = {{(PW2-1){1'b0}}, 1'b1} << (PW2 - LOG2N + STAGE);
    localparam logic [BLK_W-1:0] J_LAST_LOW = {BLK_W{1'b1}} >> 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [LOG2N-1:0] n;
    logic [LOG2N-1:0] n_cur;
    logic [PW2-1:0]   acc;
    logic [PW2-1:0]   phase;
    logic [BLK_W-1:0] j;
    logic             accept;
    logic             restart;
    logic             discard;
    logic             upper;

    // n_cur is the frame index this cycle's sample will be given.
    always_comb begin
        accept  = 1'b0;
        restart = 1'b0;
        discard = 1'b0;
        n_cur   = n;
        if (in_valid) begin
            if (state == IDLE) begin
                if (in_sop) begin
                    accept = 1'b1;
                    n_cur  = '0;
                end else begin
                    discard = 1'b1;
                end
            end else begin
                accept = 1'b1;
                if (in_sop && (n != '1)) begin
                    restart = 1'b1;
                    n_cur   = '0;
                end
            end
        end
    end

    // The upper half of each block gets the running negative-step phase.
    assign j     = n_cur[BLK_W-1:0];
    assign upper = j[BLK_W-1];
    assign phase = upper ? acc : '0;

    // ---- stage boundary: input -> registered output (1 cycle) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            sop_err   <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            angle     <= '0;
            quad      <= '0;
        end else begin
            out_valid <= accept;
            out_sop   <= accept && (n_cur == '0);
            sop_err   <= discard | restart;
            if (accept) begin
                out_real <= in_real;
                out_imag <= in_imag;
                quad     <= phase[PW2-1:PHASE_WIDTH];
                angle    <= phase[PHASE_WIDTH-1:0];
                n        <= n_cur + 1'b1;
                state    <= (n_cur == '1) ? IDLE : RUN;
                if (upper) begin
                    acc <= acc - STEP;
                end else if (j == J_LAST_LOW) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule
